// File: rtl/mpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mpu_pkg                                                       |
// | Brief  : Shared widths, mode encodings, feeder states, weight fields.  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package mpu_pkg;

    localparam int c_DATA_WIDTH         = 8;
    localparam int c_SPARSE_INDEX_WIDTH = 4;

    localparam logic c_MODE_DENSE  = 1'b0;
    localparam logic c_MODE_SPARSE = 1'b1;

    // Weight word is {sparse_index, weight}: weight in the low bits.
    localparam int c_WGT_FIELD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } feeder_state_t;

    function automatic int idx_field_lsb(input int data_width);
        return c_WGT_FIELD_LSB + data_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_feeder_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mpu_feeder_addr_gen                                           |
// | Brief  : Activation/weight address counters with remaining-length      |
// |          count; addresses wrap modulo 2^ADDR_WIDTH.                    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module mpu_feeder_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [ADDR_WIDTH-1:0] i_act_base,
    input  logic [ADDR_WIDTH-1:0] i_wgt_base,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic [ADDR_WIDTH-1:0] o_act_addr,
    output logic [ADDR_WIDTH-1:0] o_wgt_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_act_addr;
    logic [ADDR_WIDTH-1:0] r_wgt_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_addr  <= '0;
            r_wgt_addr  <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_act_addr  <= i_act_base;
            r_wgt_addr  <= i_wgt_base;
            r_remaining <= i_len;
        end else if (i_advance) begin
            r_act_addr  <= r_act_addr + ADDR_WIDTH'(1);
            r_wgt_addr  <= r_wgt_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
    end

    assign o_act_addr = r_act_addr;
    assign o_wgt_addr = r_wgt_addr;
    assign o_last     = (r_remaining == LEN_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/mpu_operand_feeder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mpu_operand_feeder                                            |
// | Brief  : Reads activation/weight SRAMs for one command and streams     |
// |          operands to the MPU; sparse mode skips zero weights.          |
// |          MPU_FEEDER_PERF_EN adds perf_issued/perf_skipped counters.    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module mpu_operand_feeder
    import mpu_pkg::*;
#(
    parameter int DATA_WIDTH         = c_DATA_WIDTH,
    parameter int SPARSE_INDEX_WIDTH = c_SPARSE_INDEX_WIDTH,
    parameter int ADDR_WIDTH         = 10,
    parameter int LEN_WIDTH          = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                cmd_act_base,
    input  logic [ADDR_WIDTH-1:0]                cmd_wgt_base,
    input  logic [LEN_WIDTH-1:0]                 cmd_len,
    input  logic                                 cmd_mode,
    output logic                                 act_rd_en,
    output logic [ADDR_WIDTH-1:0]                act_rd_addr,
    input  logic [DATA_WIDTH-1:0]                act_rd_data,
    output logic                                 wgt_rd_en,
    output logic [ADDR_WIDTH-1:0]                wgt_rd_addr,
    input  logic [SPARSE_INDEX_WIDTH+DATA_WIDTH-1:0] wgt_rd_data,
    output logic [DATA_WIDTH-1:0]                mpu_activation,
    output logic [DATA_WIDTH-1:0]                mpu_weight,
    output logic [SPARSE_INDEX_WIDTH-1:0]        mpu_sparse_index,
    output logic                                 mpu_mode,
    output logic                                 mpu_start,
    input  logic                                 mpu_done,
`ifdef MPU_FEEDER_PERF_EN
    output logic [LEN_WIDTH-1:0]                 perf_issued,
    output logic [LEN_WIDTH-1:0]                 perf_skipped,
`endif
    output logic                                 busy,
    output logic                                 cmd_done
);

    localparam int c_IDX_LSB = idx_field_lsb(DATA_WIDTH);

    feeder_state_t                 r_state;
    logic                          r_rd_vld;
    logic                          r_armed;
    logic                          r_any_issued;
    logic                          w_handshake;
    logic                          w_issue;
    logic                          w_last;
    logic                          w_skip;
    logic [DATA_WIDTH-1:0]         w_wgt;
    logic [SPARSE_INDEX_WIDTH-1:0] w_idx;

    assign w_handshake = cmd_valid && (r_state == ST_IDLE);
    assign w_issue     = (r_state == ST_READ);
    assign w_wgt       = wgt_rd_data[c_WGT_FIELD_LSB +: DATA_WIDTH];
    assign w_idx       = wgt_rd_data[c_IDX_LSB +: SPARSE_INDEX_WIDTH];
    assign w_skip      = (mpu_mode == c_MODE_SPARSE) && (w_wgt == '0);

    mpu_feeder_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_handshake),
        .i_advance  (w_issue),
        .i_act_base (cmd_act_base),
        .i_wgt_base (cmd_wgt_base),
        .i_len      (cmd_len),
        .o_act_addr (act_rd_addr),
        .o_wgt_addr (wgt_rd_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_rd_vld         <= 1'b0;
            r_armed          <= 1'b0;
            r_any_issued     <= 1'b0;
            mpu_activation   <= '0;
            mpu_weight       <= '0;
            mpu_sparse_index <= '0;
            mpu_mode         <= c_MODE_DENSE;
            mpu_start        <= 1'b0;
            cmd_done         <= 1'b0;
`ifdef MPU_FEEDER_PERF_EN
            perf_issued      <= '0;
            perf_skipped     <= '0;
`endif
        end else begin
            cmd_done  <= 1'b0;
            mpu_start <= 1'b0;
            r_rd_vld  <= w_issue;

            // Skipped elements leave the data outputs holding the last issued values.
            if (r_rd_vld) begin
                if (w_skip) begin
`ifdef MPU_FEEDER_PERF_EN
                    perf_skipped <= perf_skipped + LEN_WIDTH'(1);
`endif
                end else begin
                    mpu_start        <= 1'b1;
                    mpu_activation   <= act_rd_data;
                    mpu_weight       <= w_wgt;
                    mpu_sparse_index <= w_idx;
                    r_any_issued     <= 1'b1;
`ifdef MPU_FEEDER_PERF_EN
                    perf_issued      <= perf_issued + LEN_WIDTH'(1);
`endif
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        mpu_mode     <= cmd_mode;
                        r_any_issued <= 1'b0;
                        r_armed      <= 1'b0;
`ifdef MPU_FEEDER_PERF_EN
                        perf_issued  <= '0;
                        perf_skipped <= '0;
`endif
                        r_state      <= (cmd_len == '0) ? ST_FINISH : ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // First cycle here is the last element's output cycle; done counts only after it.
                    r_armed <= 1'b1;
                    if (!r_any_issued || (r_armed && mpu_done)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    cmd_done <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign act_rd_en = w_issue;
    assign wgt_rd_en = w_issue;

endmodule
`default_nettype wire

// File: tb/tb_mpu_operand_feeder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mpu_operand_feeder                                         |
// | Brief  : Scoreboard bench for mpu_operand_feeder with SRAM models.     |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mpu_operand_feeder;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int MAXC = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_act_base = '0;
    logic [AW-1:0] cmd_wgt_base = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_mode = 1'b0;
    logic          act_rd_en, wgt_rd_en;
    logic [AW-1:0] act_rd_addr, wgt_rd_addr;
    logic [DW-1:0] act_rd_data = '0;
    logic [IW+DW-1:0] wgt_rd_data = '0;
    logic [DW-1:0] mpu_activation, mpu_weight;
    logic [IW-1:0] mpu_sparse_index;
    logic          mpu_mode, mpu_start, busy, cmd_done;
    logic          mpu_done = 1'b0;
`ifdef MPU_FEEDER_PERF_EN
    logic [LW-1:0] perf_issued, perf_skipped;
`endif

    mpu_operand_feeder #(.DATA_WIDTH(DW), .SPARSE_INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act_base(cmd_act_base), .cmd_wgt_base(cmd_wgt_base), .cmd_len(cmd_len), .cmd_mode(cmd_mode),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .mpu_activation(mpu_activation), .mpu_weight(mpu_weight), .mpu_sparse_index(mpu_sparse_index),
        .mpu_mode(mpu_mode), .mpu_start(mpu_start), .mpu_done(mpu_done),
`ifdef MPU_FEEDER_PERF_EN
        .perf_issued(perf_issued), .perf_skipped(perf_skipped),
`endif
        .busy(busy), .cmd_done(cmd_done)
    );

    // One-cycle-latency SRAM models.
    logic [DW-1:0]    act_mem [1<<AW];
    logic [IW+DW-1:0] wgt_mem [1<<AW];
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
        if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
    end

    typedef struct {
        int            cyc;
        logic [DW-1:0] a;
        logic [DW-1:0] w;
        logic [IW-1:0] ix;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int failures = 0;

    // Per-cycle observation log; cycle 1 is the first cycle after the handshake edge.
    logic          o_st [MAXC], o_mode [MAXC], o_cd [MAXC], o_ren [MAXC], o_wen [MAXC], o_rdy [MAXC], o_bsy [MAXC];
    logic [DW-1:0] o_a [MAXC], o_w [MAXC];
    logic [IW-1:0] o_ix [MAXC];
    logic [AW-1:0] o_aad [MAXC], o_wad [MAXC];

    task automatic issue_cmd(input logic [AW-1:0] ab, input logic [AW-1:0] wb, input logic [LW-1:0] len, input logic mode);
        @(posedge clk); #1;
        cmd_act_base = ab; cmd_wgt_base = wb; cmd_len = len; cmd_mode = mode; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_act_base = ~ab; cmd_wgt_base = ~wb; cmd_len = '0; cmd_mode = ~mode;
    endtask

    task automatic observe(input int n, input int done_c, input int early_c, input int rst_c, input int bv_c);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            o_st[c] = mpu_start; o_a[c] = mpu_activation; o_w[c] = mpu_weight; o_ix[c] = mpu_sparse_index;
            o_mode[c] = mpu_mode; o_cd[c] = cmd_done; o_ren[c] = act_rd_en; o_wen[c] = wgt_rd_en;
            o_aad[c] = act_rd_addr; o_wad[c] = wgt_rd_addr; o_rdy[c] = cmd_ready; o_bsy[c] = busy;
            mpu_done  = (c + 1 == done_c) || (c + 1 == early_c);
            rst       = (c == rst_c);
            cmd_valid = (c < bv_c);
        end
        mpu_done = 1'b0; rst = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mpu_start, mpu_activation, mpu_weight, mpu_sparse_index, mpu_mode, act_rd_en, wgt_rd_en,
             act_rd_addr, wgt_rd_addr, busy, cmd_done} !== '0 || cmd_ready !== 1'b1)
            begin failures++; $display("FAIL reset_outputs start=%b act=%0d busy=%b done=%b ready=%b required all 0 ready=1",
                                       mpu_start, mpu_activation, busy, cmd_done, cmd_ready); end
        rst = 1'b0;
    endtask

    task automatic test_dense;
        int n_cd, cd_c;
        for (int k = 0; k < 4; k++) begin
            act_mem[k] = DW'(k + 1); wgt_mem[k] = {4'd0, DW'(k + 5)};
            sb.push_back('{cyc: 3 + k, a: DW'(k + 1), w: DW'(k + 5), ix: 4'd0});
        end
        issue_cmd(10'd0, 10'd0, 11'd4, 1'b0);
        cmd_len = 11'd2;
        observe(20, 12, 6, 0, 5);
        for (int c = 1; c <= 20; c++) if (o_st[c]) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL dense_extra_start cycle=%0d required none", c); end
            else begin
                e = sb.pop_front();
                if (c != e.cyc || o_a[c] !== e.a || o_w[c] !== e.w)
                    begin failures++; $display("FAIL dense_elem cycle=%0d act=%0d wgt=%0d required cycle=%0d act=%0d wgt=%0d",
                                               c, o_a[c], o_w[c], e.cyc, e.a, e.w); end
            end
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL dense_missing got %0d unissued required 0", sb.size()); sb.delete(); end
        n_cd = 0; cd_c = 0;
        for (int c = 1; c <= 20; c++) if (o_cd[c]) begin n_cd++; cd_c = c; end
        checks++;
        if (n_cd != 1 || cd_c < 13 || cd_c > 14)
            begin failures++; $display("FAIL dense_cmd_done count=%0d cycle=%0d required count=1 cycle 13..14", n_cd, cd_c); end
    endtask

    task automatic test_sparse;
        int n_cd;
        logic [DW-1:0] wv [4];
        wv[0] = 8'd3; wv[1] = 8'd0; wv[2] = 8'd0; wv[3] = 8'd9;
        for (int k = 0; k < 4; k++) begin
            act_mem[100 + k] = DW'(10 + k); wgt_mem[200 + k] = {IW'(k + 1), wv[k]};
        end
        sb.push_back('{cyc: 3, a: 8'd10, w: 8'd3, ix: 4'd1});
        sb.push_back('{cyc: 6, a: 8'd13, w: 8'd9, ix: 4'd4});
        issue_cmd(10'd100, 10'd200, 11'd4, 1'b1);
        observe(16, 9, 0, 0, 0);
        for (int c = 1; c <= 16; c++) if (o_st[c]) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL sparse_extra_start cycle=%0d required none", c); end
            else begin
                e = sb.pop_front();
                if (c != e.cyc || o_a[c] !== e.a || o_w[c] !== e.w || o_ix[c] !== e.ix)
                    begin failures++; $display("FAIL sparse_elem cycle=%0d act=%0d wgt=%0d idx=%0d required cycle=%0d act=%0d wgt=%0d idx=%0d",
                                               c, o_a[c], o_w[c], o_ix[c], e.cyc, e.a, e.w, e.ix); end
            end
        end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sparse_missing got %0d unissued required 0", sb.size()); sb.delete(); end
        checks++;
        if ({o_a[4], o_w[4], o_ix[4], o_a[5], o_w[5], o_ix[5]} !== {8'd10, 8'd3, 4'd1, 8'd10, 8'd3, 4'd1})
            begin failures++; $display("FAIL sparse_bubble_hold act=%0d wgt=%0d idx=%0d required act=10 wgt=3 idx=1", o_a[5], o_w[5], o_ix[5]); end
        checks++;
        if (o_mode[3] !== 1'b1) begin failures++; $display("FAIL sparse_mode got %b required 1", o_mode[3]); end
        n_cd = 0;
        for (int c = 1; c <= 16; c++) if (o_cd[c]) n_cd++;
        checks++;
        if (n_cd != 1) begin failures++; $display("FAIL sparse_cmd_done count=%0d required 1", n_cd); end
`ifdef MPU_FEEDER_PERF_EN
        checks++;
        if (perf_issued !== 11'd2 || perf_skipped !== 11'd2)
            begin failures++; $display("FAIL sparse_perf issued=%0d skipped=%0d required 2 2", perf_issued, perf_skipped); end
`endif
    endtask

    task automatic test_all_skipped;
        int n_st, n_cd, cd_c;
        for (int k = 0; k < 3; k++) begin
            act_mem[300 + k] = DW'(50 + k); wgt_mem[300 + k] = {IW'(k + 7), 8'd0};
        end
        issue_cmd(10'd300, 10'd300, 11'd3, 1'b1);
        observe(15, 0, 0, 0, 0);
        n_st = 0; n_cd = 0; cd_c = 0;
        for (int c = 1; c <= 15; c++) begin
            if (o_st[c]) n_st++;
            if (o_cd[c]) begin n_cd++; cd_c = c; end
        end
        checks++;
        if (n_st != 0) begin failures++; $display("FAIL skipped_start count=%0d required 0", n_st); end
        checks++;
        if (n_cd != 1 || cd_c > 9) begin failures++; $display("FAIL skipped_cmd_done count=%0d cycle=%0d required count=1 cycle<=9", n_cd, cd_c); end
`ifdef MPU_FEEDER_PERF_EN
        checks++;
        if (perf_issued !== 11'd0 || perf_skipped !== 11'd3)
            begin failures++; $display("FAIL skipped_perf issued=%0d skipped=%0d required 0 3", perf_issued, perf_skipped); end
`endif
    endtask

    task automatic test_len_zero;
        int n_cd, n_rd;
        issue_cmd(10'd5, 10'd5, 11'd0, 1'b0);
        observe(8, 0, 0, 0, 0);
        n_cd = 0; n_rd = 0;
        for (int c = 1; c <= 8; c++) begin
            if (o_cd[c]) n_cd++;
            if (o_ren[c] || o_wen[c] || o_st[c]) n_rd++;
        end
        checks++;
        if (o_cd[2] !== 1'b1 || n_cd != 1) begin failures++; $display("FAIL len0_cmd_done at2=%b count=%0d required 1 1", o_cd[2], n_cd); end
        checks++;
        if (n_rd != 0) begin failures++; $display("FAIL len0_reads count=%0d required 0", n_rd); end
        checks++;
        if (o_rdy[1] !== 1'b0 || o_rdy[2] !== 1'b1) begin failures++; $display("FAIL len0_ready c1=%b c2=%b required 0 1", o_rdy[1], o_rdy[2]); end
    endtask

    task automatic test_reset_mid;
        int n_bad;
        for (int k = 0; k < 8; k++) begin
            act_mem[400 + k] = DW'(30 + k); wgt_mem[400 + k] = {IW'(k), DW'(60 + k)};
        end
        issue_cmd(10'd400, 10'd400, 11'd8, 1'b1);
        observe(20, 0, 0, 3, 0);
        checks++;
        if (o_st[3] !== 1'b1 || o_a[3] !== 8'd30 || o_w[3] !== 8'd60)
            begin failures++; $display("FAIL rstmid_first start=%b act=%0d wgt=%0d required 1 30 60", o_st[3], o_a[3], o_w[3]); end
        checks++;
        if ({o_st[4], o_a[4], o_w[4], o_ix[4], o_mode[4], o_ren[4], o_wen[4], o_aad[4], o_wad[4], o_cd[4], o_bsy[4]} !== '0
            || o_rdy[4] !== 1'b1)
            begin failures++; $display("FAIL rstmid_outputs start=%b act=%0d mode=%b rd=%b addr=%0d busy=%b ready=%b required all 0 ready=1",
                                       o_st[4], o_a[4], o_mode[4], o_ren[4], o_aad[4], o_bsy[4], o_rdy[4]); end
        n_bad = 0;
        for (int c = 4; c <= 20; c++) if (o_st[c] || o_cd[c]) n_bad++;
        checks++;
        if (n_bad != 0) begin failures++; $display("FAIL rstmid_activity count=%0d required 0", n_bad); end
`ifdef MPU_FEEDER_PERF_EN
        checks++;
        if (perf_issued !== 11'd0 || perf_skipped !== 11'd0)
            begin failures++; $display("FAIL rstmid_perf issued=%0d skipped=%0d required 0 0", perf_issued, perf_skipped); end
`endif
    endtask

    task automatic test_wrap;
        int n_rd, n_cd;
        logic [AW-1:0] ea;
        for (int k = 0; k < 4; k++) begin
            ea = AW'(1022 + k);
            act_mem[ea] = DW'(21 + k); wgt_mem[5 + k] = {IW'(k + 2), DW'(70 + k)};
            sb.push_back('{cyc: 3 + k, a: DW'(21 + k), w: DW'(70 + k), ix: IW'(k + 2)});
        end
        issue_cmd(10'd1022, 10'd5, 11'd4, 1'b0);
        observe(16, 10, 0, 0, 0);
        n_rd = 0;
        for (int c = 1; c <= 16; c++) if (o_ren[c]) begin
            ea = AW'(1022 + n_rd);
            checks++;
            if (c != n_rd + 1 || o_aad[c] !== ea || o_wad[c] !== AW'(5 + n_rd) || o_wen[c] !== 1'b1)
                begin failures++; $display("FAIL wrap_addr cycle=%0d act_addr=%0d wgt_addr=%0d required cycle=%0d act_addr=%0d wgt_addr=%0d",
                                           c, o_aad[c], o_wad[c], n_rd + 1, ea, 5 + n_rd); end
            n_rd++;
        end
        checks++;
        if (n_rd != 4) begin failures++; $display("FAIL wrap_read_count got %0d required 4", n_rd); end
        n_cd = 0;
        for (int c = 1; c <= 16; c++) begin
            if (o_cd[c]) n_cd++;
            if (o_st[c]) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL wrap_extra_start cycle=%0d required none", c); end
                else begin
                    e = sb.pop_front();
                    if (c != e.cyc || o_a[c] !== e.a || o_w[c] !== e.w || o_ix[c] !== e.ix)
                        begin failures++; $display("FAIL wrap_elem cycle=%0d act=%0d wgt=%0d required cycle=%0d act=%0d wgt=%0d",
                                                   c, o_a[c], o_w[c], e.cyc, e.a, e.w); end
                end
            end
        end
        checks++;
        if (sb.size() != 0 || n_cd != 1)
            begin failures++; $display("FAIL wrap_completion unissued=%0d cmd_done=%0d required 0 1", sb.size(), n_cd); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_dense();
        test_sparse();
        test_all_skipped();
        test_len_zero();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
